// File: rtl/pixel_job_sequencer.sv
// rtl/pixel_job_sequencer.sv - job sequencer driving raster scans for the pixel datapath
//
// Accepts BRIGHTNESS(0)/GRAYSCALE(1)/ROTATE(2) jobs over a valid/ready handshake.
// For each job it latches the image dimensions, then issues a row-major scan of
// row/column addresses with writer backpressure. It also pulses frame start/done
// markers.
//
// Build option: define JOB_QUEUE_EN for a QUEUE_DEPTH-entry job FIFO that accepts jobs
// while busy. Otherwise a single pending-job register accepts jobs only when idle.
//
// Ports:
//   clk_i, rst_ni                  clock (rising edge), asynchronous active-low reset
//   job_valid_i/job_opcode_i       job request; job_ready_o accepts it
//   img_width_i/img_height_i       image dimensions from the reader, latched at LOAD
//   stall_i                        writer backpressure, holds the scan position
//   opcode_o                       operation presented to processing
//   scan_row_o/scan_col_o          current pixel address, qualified by pix_valid_o
//   frame_start_o/frame_done_o     frame markers
//   busy_o                         sequencer not idle
//   err_opcode_o                   pulse after a rejected opcode-3 job
module pixel_job_sequencer #(
    parameter int DIM_W        = 12,
    parameter int QUEUE_DEPTH  = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             job_valid_i,
    input  logic [1:0]       job_opcode_i,
    output logic             job_ready_o,
    input  logic [DIM_W-1:0] img_width_i,
    input  logic [DIM_W-1:0] img_height_i,
    input  logic             stall_i,
    output logic [1:0]       opcode_o,
    output logic [DIM_W-1:0] scan_row_o,
    output logic [DIM_W-1:0] scan_col_o,
    output logic             pix_valid_o,
    output logic             frame_start_o,
    output logic             frame_done_o,
    output logic             busy_o,
    output logic             err_opcode_o
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_DRAIN, S_DONE} state_e;

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e           state_q;
    logic [1:0]       opcode_q;
    logic [DIM_W-1:0] width_q, height_q, row_q, col_q;
    logic [DCW-1:0]   drain_q;
    logic             err_q;
    logic             ready_en_q;   // keeps job_ready_o low until the first edge after reset

    logic             job_accept, job_push, job_pop, job_pending;
    logic [1:0]       head_op;
    logic             col_last, row_last;

    assign job_accept = job_valid_i && job_ready_o;
    // Opcode 3 is consumed by the handshake but never becomes a job.
    assign job_push   = job_accept && (job_opcode_i != 2'd3);
    assign job_pop    = (state_q == S_LOAD);

`ifdef JOB_QUEUE_EN
    localparam int QW = $clog2(QUEUE_DEPTH);

    logic [1:0]  q_mem_q [QUEUE_DEPTH];
    logic [QW-1:0] q_wr_q, q_rd_q;
    logic [QW:0]   q_cnt_q, q_cnt_d;

    assign q_cnt_d     = q_cnt_q + (QW+1)'(job_push) - (QW+1)'(job_pop);
    assign job_pending = (q_cnt_q != '0);
    assign head_op     = q_mem_q[q_rd_q];
    assign job_ready_o = ready_en_q && (q_cnt_q != (QW+1)'(QUEUE_DEPTH));

    always_ff @(posedge clk_i) begin
        if (job_push) begin
            q_mem_q[q_wr_q] <= job_opcode_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_wr_q  <= '0;
            q_rd_q  <= '0;
            q_cnt_q <= '0;
        end else begin
            if (job_push) q_wr_q <= q_wr_q + 1'b1;
            if (job_pop)  q_rd_q <= q_rd_q + 1'b1;
            q_cnt_q <= q_cnt_d;
        end
    end
`else
    logic       pend_valid_q;
    logic [1:0] pend_op_q;

    assign job_pending = pend_valid_q;
    assign head_op     = pend_op_q;
    assign job_ready_o = ready_en_q && (state_q == S_IDLE) && !pend_valid_q;

    // Push and pop never coincide: a push requires IDLE, a pop happens in LOAD.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= 1'b0;
            pend_op_q    <= 2'd0;
        end else if (job_push) begin
            pend_valid_q <= 1'b1;
            pend_op_q    <= job_opcode_i;
        end else if (job_pop) begin
            pend_valid_q <= 1'b0;
        end
    end
`endif

    assign col_last = (col_q == width_q - DIM_W'(1));
    assign row_last = (row_q == height_q - DIM_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            opcode_q   <= 2'd0;
            width_q    <= '0;
            height_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            drain_q    <= '0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            err_q      <= job_accept && (job_opcode_i == 2'd3);
            case (state_q)
                S_IDLE: begin
                    if (job_pending) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    opcode_q <= head_op;
                    width_q  <= img_width_i;
                    height_q <= img_height_i;
                    row_q    <= '0;
                    col_q    <= '0;
                    if (img_width_i == '0 || img_height_i == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!stall_i) begin
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                // Park at (0,0) so counters stay inside the frame.
                                row_q   <= '0;
                                drain_q <= '0;
                                state_q <= S_DRAIN;
                            end else begin
                                row_q <= row_q + DIM_W'(1);
                            end
                        end else begin
                            col_q <= col_q + DIM_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q + DCW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= job_pending ? S_LOAD : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign opcode_o      = opcode_q;
    assign scan_row_o    = row_q;
    assign scan_col_o    = col_q;
    assign pix_valid_o   = (state_q == S_SCAN) && !stall_i;
    assign frame_start_o = pix_valid_o && (row_q == '0) && (col_q == '0);
    assign frame_done_o  = (state_q == S_DONE);
    assign busy_o        = (state_q != S_IDLE);
    assign err_opcode_o  = err_q;
endmodule

// File: tb/tb_pixel_job_sequencer.sv
// tb/tb_pixel_job_sequencer.sv - self-checking bench for pixel_job_sequencer
module tb_pixel_job_sequencer;
    localparam int DIM_W = 12;
    localparam int DRAIN = 2;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             job_valid_i = 1'b0;
    logic [1:0]       job_opcode_i = 2'd0;
    logic             job_ready_o;
    logic [DIM_W-1:0] img_width_i = '0;
    logic [DIM_W-1:0] img_height_i = '0;
    logic             stall_i = 1'b0;
    logic [1:0]       opcode_o;
    logic [DIM_W-1:0] scan_row_o, scan_col_o;
    logic             pix_valid_o, frame_start_o, frame_done_o, busy_o, err_opcode_o;

    pixel_job_sequencer #(.DIM_W(DIM_W), .QUEUE_DEPTH(4), .DRAIN_CYCLES(DRAIN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .job_valid_i(job_valid_i), .job_opcode_i(job_opcode_i),
        .job_ready_o(job_ready_o), .img_width_i(img_width_i), .img_height_i(img_height_i),
        .stall_i(stall_i), .opcode_o(opcode_o), .scan_row_o(scan_row_o), .scan_col_o(scan_col_o),
        .pix_valid_o(pix_valid_o), .frame_start_o(frame_start_o), .frame_done_o(frame_done_o),
        .busy_o(busy_o), .err_opcode_o(err_opcode_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int         r;
        int         c;
        logic [1:0] op;
    } px_t;
    px_t exp_q[$];

    int n_cmp = 0, n_bad = 0;
    int pix_cnt = 0, done_cnt = 0, err_cnt = 0;
    int fs_cyc = -1, last_done = -1, err_cyc = -1;
    int done_list[$];
    bit busy_seen = 0, ready_busy = 0, hit11 = 0;
    logic jv = 1'b0;
    logic [1:0] jop = 2'd0;
    int st_lo = 0, st_hi = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        px_t e;
        if (pix_valid_o) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pixel", 32'(pix_valid_o), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("pix_row", 32'(scan_row_o), 32'(e.r));
                chk("pix_col", 32'(scan_col_o), 32'(e.c));
                chk("pix_op", 32'(opcode_o), 32'(e.op));
                chk("pix_fs", 32'(frame_start_o), 32'((e.r == 0) && (e.c == 0)));
                if (e.r == 1 && e.c == 1) hit11 = 1;
            end
            if (frame_start_o) fs_cyc = cyc;
        end else begin
            chk("fs_without_pixel", 32'(frame_start_o), 32'(0));
        end
        if (stall_i) chk("stall_pix", 32'(pix_valid_o), 32'(0));
        if (frame_done_o) begin
            done_cnt++;
            last_done = cyc;
            done_list.push_back(cyc);
        end
        if (err_opcode_o) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (busy_o) busy_seen = 1;
        if (busy_o && job_ready_o) ready_busy = 1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        job_valid_i  = jv;
        job_opcode_i = jop;
        stall_i      = (cyc >= st_lo) && (cyc < st_hi);
        @(negedge clk_i);
        sample();
    endtask

    // Returns the cycle index N of the accepting edge and the cycles spent waiting for ready.
    task automatic submit(input logic [1:0] op, output int acc, output int waited);
        waited = 0;
        jop = op;
        jv  = 1'b1;
        tick();
        while (!job_ready_o && waited < 200) begin
            tick();
            waited++;
        end
        chk("accept_timeout", 32'(waited < 200), 32'(1));
        jv = 1'b0;
        tick();
        acc = cyc;
    endtask

    task automatic push_frame(input int w, input int h, input logic [1:0] op);
        px_t e;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                e.r = r; e.c = c; e.op = op;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_until_done(input int bound);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < bound) begin
            tick();
            k++;
        end
        chk("done_timeout", 32'(done_cnt != d0), 32'(1));
    endtask

    initial begin
        int n, w, p0, d0, k;
        logic [1:0] ops [5];
        ops[0] = 2'd0; ops[1] = 2'd1; ops[2] = 2'd2; ops[3] = 2'd0; ops[4] = 2'd1;

        // Reset values
        tick(); tick();
        chk("rst_ready", 32'(job_ready_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_opcode", 32'(opcode_o), 32'(0));
        chk("rst_pix", 32'(pix_valid_o), 32'(0));
        chk("rst_done", 32'(frame_done_o), 32'(0));
        rst_ni = 1'b1;
        tick();
        chk("ready_after_release", 32'(job_ready_o), 32'(1));

        // GRAYSCALE 4x2, no stall
        img_width_i = 12'd4; img_height_i = 12'd2;
        push_frame(4, 2, 2'd1);
        busy_seen = 0; ready_busy = 0;
        submit(2'd1, n, w);
        run_until_done(60);
        chk("gray_fs_cyc", 32'(fs_cyc), 32'(n + 2));
        chk("gray_done_cyc", 32'(last_done), 32'(n + 12));
        chk("gray_sb_empty", 32'(exp_q.size()), 32'(0));
        chk("gray_opcode", 32'(opcode_o), 32'(1));
`ifndef JOB_QUEUE_EN
        chk("ready_low_while_busy", 32'(ready_busy), 32'(0));
`endif
        tick();

        // Same job, STALL for 3 cycles at pixel (0,2)
        push_frame(4, 2, 2'd1);
        submit(2'd1, n, w);
        st_lo = n + 4; st_hi = n + 7;
        p0 = pix_cnt;
        run_until_done(60);
        st_lo = 0; st_hi = 0;
        chk("stall_fs_cyc", 32'(fs_cyc), 32'(n + 2));
        chk("stall_done_cyc", 32'(last_done), 32'(n + 15));
        chk("stall_pix_cnt", 32'(pix_cnt - p0), 32'(8));
        chk("stall_sb_empty", 32'(exp_q.size()), 32'(0));
        tick();

        // Opcode 3 rejected
        busy_seen = 0; p0 = pix_cnt; d0 = err_cnt;
        submit(2'd3, n, w);
        repeat (6) tick();
        chk("err_count", 32'(err_cnt - d0), 32'(1));
        chk("err_cyc", 32'(err_cyc), 32'(n));
        chk("err_busy", 32'(busy_seen), 32'(0));
        chk("err_no_pix", 32'(pix_cnt - p0), 32'(0));

        // Zero width: LOAD then DONE
        img_width_i = 12'd0; img_height_i = 12'd2;
        p0 = pix_cnt;
        submit(2'd2, n, w);
        run_until_done(20);
        chk("w0_done_cyc", 32'(last_done), 32'(n + 2));
        chk("w0_no_pix", 32'(pix_cnt - p0), 32'(0));
        chk("w0_opcode", 32'(opcode_o), 32'(2));
        tick();

`ifdef JOB_QUEUE_EN
        // Five jobs pushed while busy into a depth-4 queue
        img_width_i = 12'd4; img_height_i = 12'd4;
        push_frame(4, 4, 2'd2);
        p0 = pix_cnt;
        submit(2'd2, n, w);
        k = 0;
        while (pix_cnt == p0 && k < 20) begin tick(); k++; end
        done_list.delete();
        for (int i = 0; i < 5; i++) begin
            push_frame(4, 4, ops[i]);
            submit(ops[i], n, w);
            if (i < 4) chk("q_no_wait", 32'(w), 32'(0));
            else       chk("q5_waited", 32'(w > 0), 32'(1));
            if (i == 3) chk("q_full_ready", 32'(job_ready_o), 32'(0));
        end
        k = 0;
        while (done_list.size() < 6 && k < 300) begin tick(); k++; end
        chk("q_frames_done", 32'(done_list.size()), 32'(6));
        for (int i = 1; i < 6 && i < done_list.size(); i++) begin
            chk("q_frame_spacing", 32'(done_list[i] - done_list[i-1]), 32'(16 + DRAIN + 2));
        end
        chk("q_sb_empty", 32'(exp_q.size()), 32'(0));
        tick();
`endif

        // Reset at pixel (1,1) of a 4x4 job
        img_width_i = 12'd4; img_height_i = 12'd4;
        push_frame(4, 4, 2'd2);
        hit11 = 0;
        submit(2'd2, n, w);
`ifdef JOB_QUEUE_EN
        submit(2'd1, n, w);
`endif
        k = 0;
        while (!hit11 && k < 60) begin tick(); k++; end
        chk("reach_pixel_11", 32'(hit11), 32'(1));
        rst_ni = 1'b0;
        #1;
        chk("abort_ready", 32'(job_ready_o), 32'(0));
        chk("abort_pix", 32'(pix_valid_o), 32'(0));
        chk("abort_fs", 32'(frame_start_o), 32'(0));
        chk("abort_done", 32'(frame_done_o), 32'(0));
        chk("abort_busy", 32'(busy_o), 32'(0));
        chk("abort_err", 32'(err_opcode_o), 32'(0));
        chk("abort_opcode", 32'(opcode_o), 32'(0));
        chk("abort_row", 32'(scan_row_o), 32'(0));
        chk("abort_col", 32'(scan_col_o), 32'(0));
        exp_q.delete();
        d0 = done_cnt;
        tick(); tick();
        rst_ni = 1'b1;
        busy_seen = 0;
        repeat (4) tick();
        chk("post_reset_idle", 32'(busy_seen), 32'(0));
        chk("no_done_for_abort", 32'(done_cnt), 32'(d0));

        // Fresh BRIGHTNESS job after reset
        img_width_i = 12'd2; img_height_i = 12'd2;
        push_frame(2, 2, 2'd0);
        submit(2'd0, n, w);
        run_until_done(40);
        chk("bright_fs_cyc", 32'(fs_cyc), 32'(n + 2));
        chk("bright_done_cyc", 32'(last_done), 32'(n + 2 + 4 + DRAIN));
        chk("bright_sb_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pixel_job_sequencer.md
# pixel_job_sequencer

Job sequencer that sits between the host/testbench and the `processing` datapath. It accepts image-processing jobs (BRIGHTNESS=0, GRAYSCALE=1, ROTATE=2) over a valid/ready handshake and latches image dimensions from `image_read`. For each job it drives a raster scan of row/column addresses with writer backpressure, presents the opcode to `processing`, and pulses frame start/done markers for `image_write` and the host.

## Interface
- DIM_W, 12, width of dimension and row/col buses
- QUEUE_DEPTH, 4, job queue entries (power of two; used only with JOB_QUEUE_EN)
- DRAIN_CYCLES, 2, cycles waited after the last pixel for the datapath to flush (≥1)

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- JOB_VALID  in  1  job request valid
- JOB_OPCODE  in  2  requested operation
- JOB_READY  out  1  job can be accepted this cycle
- IMG_WIDTH  in  DIM_W  image width from reader
- IMG_HEIGHT  in  DIM_W  image height from reader
- STALL  in  1  writer backpressure; hold scan position
- OPCODE  out  2  operation presented to processing
- SCAN_ROW  out  DIM_W  current pixel row
- SCAN_COL  out  DIM_W  current pixel column
- PIX_VALID  out  1  SCAN_ROW/SCAN_COL valid this cycle
- FRAME_START  out  1  one-cycle pulse with first pixel of a frame
- FRAME_DONE  out  1  one-cycle pulse at end of a frame
- BUSY  out  1  state ≠ IDLE
- ERR_OPCODE  out  1  one-cycle pulse when a job with opcode 3 is rejected

## Operation
- Job accepted on a rising edge with JOB_VALID && JOB_READY. Opcode 3 is consumed but not queued; ERR_OPCODE pulses the following cycle.
- FSM states: IDLE, LOAD, SCAN, DRAIN, DONE.
  - IDLE → LOAD when a job is pending.
  - LOAD (1 cycle): pop the job, latch opcode to OPCODE, and latch IMG_WIDTH/IMG_HEIGHT. If either dimension is 0, go to DONE with no pixels; otherwise go to SCAN with row = col = 0.
  - SCAN: row-major order, col fastest. PIX_VALID = !STALL. On each non-stalled cycle col increments; at col = W−1, col wraps to 0 and row increments. After the pixel (H−1, W−1) is issued, go to DRAIN.
  - DRAIN: count DRAIN_CYCLES, then go to DONE.
  - DONE (1 cycle): FRAME_DONE = 1. Go to LOAD if a job is pending, else IDLE.
- FRAME_START = PIX_VALID on pixel (0,0) only. If STALL is high on the first SCAN cycle, FRAME_START is delayed along with that pixel.
- Changes on IMG_WIDTH/IMG_HEIGHT/JOB_OPCODE during a frame are ignored. OPCODE holds its value until the next LOAD.
- Counters are DIM_W bits and never exceed latched dimension − 1.

## Timing
- Reset values: JOB_READY=0 while RESET is low, then 1 from the first cycle after release. OPCODE=0, SCAN_ROW=SCAN_COL=0, PIX_VALID=FRAME_START=FRAME_DONE=BUSY=ERR_OPCODE=0. The queue is emptied and the FSM is in IDLE.
- Reset asserted mid-frame aborts immediately and asynchronously. No FRAME_DONE is issued for the aborted job.
- Latency, with no stall and an empty queue:
  - Job accepted at edge N; LOAD in cycle N+1.
  - First pixel and FRAME_START in cycle N+2.
  - Last pixel in cycle N+1+W·H.
  - FRAME_DONE in cycle N+2+W·H+DRAIN_CYCLES.
- Each STALL cycle in SCAN adds exactly one cycle. STALL is ignored outside SCAN.
- Back-to-back jobs: DONE → LOAD, giving two non-pixel cycles between frames, plus the drain cycles.

## Configuration
- JOB_QUEUE_EN defined:
  - QUEUE_DEPTH-entry FIFO; JOB_READY = !full.
  - A push and pop in the same cycle are both honoured.
  - Jobs may be submitted while BUSY.
- JOB_QUEUE_EN undefined:
  - Single pending-job register.
  - JOB_READY = (state == IDLE) && no pending job.
  - No job is accepted while BUSY.

## Test plan
- Reset, then a GRAYSCALE job with W=4, H=2 → OPCODE=1; 8 PIX_VALID cycles in order (0,0)…(0,3),(1,0)…(1,3); FRAME_START in cycle N+2; FRAME_DONE in cycle N+12.
- Same job with STALL high for 3 cycles at (0,2) → position held, PIX_VALID low during the stall, FRAME_DONE at N+15.
- Job with opcode 3 → ERR_OPCODE pulses once, BUSY stays 0, no pixels issued. Job with W=0 → LOAD then DONE, no PIX_VALID.
- With JOB_QUEUE_EN: push 5 jobs with opcodes 0,1,2,0,1 while BUSY → JOB_READY drops after 4 are queued (depth 4), frames execute in order, 2 gap cycles between frames plus drain cycles. Without JOB_QUEUE_EN: JOB_READY=0 throughout the first frame.
- RESET low at pixel (1,1) of a 4×4 job → all outputs 0 immediately, queue empty; after release a new BRIGHTNESS job starts from (0,0).
